// File: rtl/debounce_pulse_gen.sv
// debounce_pulse_gen: debounces a raw button into a clean level plus one-cycle press/release strobes; define AUTO_REPEAT_EN for held-button repeat presses
module debounce_pulse_gen #(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int CW = $clog2(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   level_n, press_n, release_n;
    logic                   rpt_fire;

    assign sync = sync_q[SYNC_STAGES-1];

    if (STABLE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("debounce_pulse_gen: parameter out of range");
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;

    logic [RW-1:0] rpt_cnt;
    logic          rpt_rep;
    logic          rpt_hit;

    assign rpt_hit  = rpt_cnt == (rpt_rep ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
    assign rpt_fire = state == IDLE_HIGH && sync && rpt_hit;

    // repeat timer: runs while steadily held, freezes through a release bounce, clears once low
    always_ff @(posedge clk) begin
        if (!rst || state == IDLE_LOW || state == WAIT_HIGH) begin
            rpt_cnt <= '0;
            rpt_rep <= 1'b0;
        end else if (state == IDLE_HIGH && sync) begin
            rpt_cnt <= rpt_hit ? '0 : rpt_cnt + 1'b1;
            rpt_rep <= rpt_rep | rpt_hit;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // synchronizer chain, FSM state, stability counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q        <= '0;
            state         <= IDLE_LOW;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], btn_in};
            state         <= state_n;
            cnt           <= cnt_n;
            btn_level     <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
        end
    end

    // next state: a new level is accepted only after STABLE_CYCLES unbroken samples
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        level_n   = btn_level;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (sync) begin
                    state_n = WAIT_HIGH;
                    cnt_n   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync) state_n = IDLE_LOW;
                else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_n = IDLE_HIGH;
                    level_n = 1'b1;
                    press_n = 1'b1;
                end else cnt_n = cnt + 1'b1;
            end
            IDLE_HIGH: begin
                if (!sync) begin
                    state_n = WAIT_LOW;
                    cnt_n   = '0;
                end else press_n = rpt_fire;
            end
            WAIT_LOW: begin
                if (sync) state_n = IDLE_HIGH;
                else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_n   = IDLE_LOW;
                    level_n   = 1'b0;
                    release_n = 1'b1;
                end else cnt_n = cnt + 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_debounce_pulse_gen.sv
// tb_debounce_pulse_gen: directed and random checks of debounce_pulse_gen against a run-length reference model
module tb_debounce_pulse_gen;
    localparam int ST = 4;
    localparam int SS = 2;
    localparam int RD = 8;
    localparam int RP = 3;
    localparam int LAT = ST + SS + 1;
`ifdef AUTO_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic clk = 0;
    logic rst = 0;
    logic btn_in = 0;
    logic btn_level, press_pulse, release_pulse;

    int checks = 0;
    int fails = 0;

    // reference model state
    logic m_level = 0, m_press = 0, m_rel = 0;
    int   run = 0, age = 0;
    logic hist[$];
    logic s;

    logic [2:0] got, exp;
    assign got = {btn_level, press_pulse, release_pulse};
    assign exp = {m_level, m_press, m_rel};

    debounce_pulse_gen #(
        .STABLE_CYCLES(ST),
        .SYNC_STAGES  (SS),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    // model: input seen SS cycles late; level flips after ST+1 consecutive differing samples
    always @(posedge clk) begin
        if (!rst) begin
            hist.delete();
            for (int i = 0; i < SS; i++) hist.push_back(1'b0);
            run = 0; age = 0;
            m_level = 0; m_press = 0; m_rel = 0;
        end else begin
            hist.push_back(btn_in);
            s = hist.pop_front();
            m_press = 0; m_rel = 0;
            if (s != m_level) begin
                run++;
                if (run > ST) begin
                    m_level = s; m_press = s; m_rel = !s;
                    run = 0; age = 0;
                end
            end else begin
                if (m_level && run == 0) begin
                    age++;
`ifdef AUTO_REPEAT_EN
                    m_press = age >= RD && (age - RD) % RP == 0;
`endif
                end
                run = 0;
            end
        end
    end

    task automatic step(input logic b);
        btn_in = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input logic b, input int n);
        repeat (n) step(b);
    endtask

    task automatic test_reset;
        int np = 0, pa = 0;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (got !== 3'b000) begin fails++; $display("FAIL reset_outputs: got %b want 000", got); end
        end
        rst = 1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            checks++;
            if (got !== exp) begin fails++; $display("FAIL reset_release_model: cycle %0d got %b want %b", i, got, exp); end
            if (press_pulse) begin np++; if (pa == 0) pa = i; end
        end
        checks++;
        if (np != 1 || pa != LAT || btn_level !== 1'b1)
            begin fails++; $display("FAIL reset_release_press: count %0d at %0d level %b want 1 at %0d level 1", np, pa, btn_level, LAT); end
    endtask

    task automatic test_clean_press;
        int np = 0, nr = 0, pa = 0, ra = 0;
        settle(0, 12);
        for (int i = 1; i <= 34; i++) begin
            step(i <= 20);
            checks++;
            if (got !== exp) begin fails++; $display("FAIL clean_model: cycle %0d got %b want %b", i, got, exp); end
            if (press_pulse) begin np++; if (pa == 0) pa = i; end
            if (release_pulse) begin nr++; if (ra == 0) ra = i; end
        end
        checks++;
        if (pa != LAT || np != 1 + 3 * REP)
            begin fails++; $display("FAIL clean_press: count %0d at %0d want %0d at %0d", np, pa, 1 + 3 * REP, LAT); end
        checks++;
        if (nr != 1 || ra != 20 + LAT)
            begin fails++; $display("FAIL clean_release: count %0d at %0d want 1 at %0d", nr, ra, 20 + LAT); end
    endtask

    task automatic test_bounce;
        logic pat[5] = '{1, 0, 1, 0, 1};
        int np = 0, pa = 0;
        settle(0, 12);
        for (int i = 1; i <= 17; i++) begin
            step(i <= 5 ? pat[i-1] : 1'b1);
            checks++;
            if (got !== exp) begin fails++; $display("FAIL bounce_model: cycle %0d got %b want %b", i, got, exp); end
            if (press_pulse) begin np++; if (pa == 0) pa = i; end
        end
        checks++;
        if (np != 1 || pa != 5 + LAT - 1)
            begin fails++; $display("FAIL bounce_press: count %0d at %0d want 1 at %0d", np, pa, 5 + LAT - 1); end
        settle(0, 12);
    endtask

    task automatic test_glitch;
        int np = 0, nr = 0;
        settle(0, 4);
        for (int i = 1; i <= 14; i++) begin
            step(i <= 2);
            checks++;
            if (got !== 3'b000) begin fails++; $display("FAIL glitch_outputs: cycle %0d got %b want 000", i, got); end
            if (press_pulse) np++;
            if (release_pulse) nr++;
        end
        checks++;
        if (np + nr != 0) begin fails++; $display("FAIL glitch_pulses: got %0d want 0", np + nr); end
    endtask

    task automatic test_reset_mid_hold;
        int np = 0, pa = 0;
        settle(0, 4);
        for (int i = 1; i <= 9; i++) begin
            step(1);
            checks++;
            if (got !== exp) begin fails++; $display("FAIL midrst_pre_model: cycle %0d got %b want %b", i, got, exp); end
        end
        rst = 0;
        step(1);
        rst = 1;
        checks++;
        if (got !== 3'b000) begin fails++; $display("FAIL midrst_outputs: got %b want 000", got); end
        for (int i = 1; i <= 10; i++) begin
            step(1);
            checks++;
            if (got !== exp) begin fails++; $display("FAIL midrst_post_model: cycle %0d got %b want %b", i, got, exp); end
            if (press_pulse) begin np++; if (pa == 0) pa = i; end
        end
        checks++;
        if (np != 1 || pa != LAT) begin fails++; $display("FAIL midrst_press: count %0d at %0d want 1 at %0d", np, pa, LAT); end
        settle(0, 12);
    endtask

    task automatic test_repeat;
        int np = 0, p[3] = '{0, 0, 0};
        settle(0, 4);
        for (int i = 1; i <= LAT + 30; i++) begin
            step(1);
            checks++;
            if (got !== exp) begin fails++; $display("FAIL repeat_model: cycle %0d got %b want %b", i, got, exp); end
            if (press_pulse) begin if (np < 3) p[np] = i; np++; end
        end
        checks++;
        if (np != (REP ? 9 : 1) || p[0] != LAT)
            begin fails++; $display("FAIL repeat_count: count %0d first %0d want %0d first %0d", np, p[0], REP ? 9 : 1, LAT); end
        checks++;
        if (p[1] != (REP ? LAT + RD : 0) || p[2] != (REP ? LAT + RD + RP : 0))
            begin fails++; $display("FAIL repeat_spacing: got %0d,%0d want %0d,%0d", p[1], p[2], REP ? LAT + RD : 0, REP ? LAT + RD + RP : 0); end
        settle(0, 14);
    endtask

    task automatic test_random;
        logic b = 0;
        int left = 0;
        for (int i = 0; i < 800; i++) begin
            if (left == 0) begin
                b = $urandom_range(0, 1);
                left = $urandom_range(0, 3) == 0 ? $urandom_range(6, 20) : $urandom_range(1, 6);
            end
            left--;
            rst = $urandom_range(0, 60) != 0;
            step(b);
            checks++;
            if (got !== exp || (press_pulse && release_pulse))
                begin fails++; $display("FAIL random_model: cycle %0d got %b want %b", i, got, exp); end
        end
        rst = 1;
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_glitch;
        test_reset_mid_hold;
        test_repeat;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
